// File: rtl/iir_coeff_ctrl.sv
// Coefficient configuration controller for a cascaded-biquad IIR filter.
// Shadow bank writes, sample-aligned atomic commit to the active bank, optional filter flush.
module iir_coeff_ctrl #(
    parameter int unsigned COEFF_WIDTH  = 32,
    parameter int unsigned NUM_SECTIONS = 3,
    parameter int unsigned ADDR_WIDTH   = 4,
    parameter int unsigned FLUSH_CYCLES = 4
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      wr_valid,
    output logic                                      wr_ready,
    input  logic [ADDR_WIDTH-1:0]                     wr_addr,
    input  logic [COEFF_WIDTH-1:0]                    wr_data,
    input  logic                                      commit_req,
    input  logic                                      commit_flush,
    input  logic                                      sample_tick,
    output logic [5*NUM_SECTIONS*COEFF_WIDTH-1:0]     coeff_flat,
    output logic                                      filt_rst_n,
    output logic                                      busy,
    output logic                                      commit_done,
    output logic                                      addr_err
);

    localparam int unsigned NUM_COEFF = 5 * NUM_SECTIONS;
    localparam int unsigned CNT_W     = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_TICK,
        FLUSH
    } state_t;

    state_t                 state_q, state_d;
    logic                   flush_q, flush_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   done_d, err_d, frst_d;
    logic                   shadow_we, load_active;
    logic                   addr_ok;
    logic [COEFF_WIDTH-1:0] shadow [NUM_COEFF];

    assign addr_ok  = 32'(wr_addr) < NUM_COEFF;
    assign wr_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);

    // State register and registered control outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            flush_q     <= 1'b0;
            cnt_q       <= '0;
            filt_rst_n  <= 1'b0;
            commit_done <= 1'b0;
            addr_err    <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_q     <= flush_d;
            cnt_q       <= cnt_d;
            filt_rst_n  <= frst_d;
            commit_done <= done_d;
            addr_err    <= err_d;
        end
    end

    // Next-state and control decode
    always_comb begin
        state_d     = state_q;
        flush_d     = flush_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        shadow_we   = 1'b0;
        load_active = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (wr_valid) begin
                    if (addr_ok) shadow_we = 1'b1;
                    else         err_d     = 1'b1;
                end
                if (commit_req) begin
                    flush_d = commit_flush;
                    state_d = WAIT_TICK;
                end
            end
            WAIT_TICK: begin
                if (sample_tick) begin
                    load_active = 1'b1;
                    if (flush_q) begin
                        state_d = FLUSH;
                        cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    flush_d = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        frst_d = (state_d != FLUSH);
    end

    // Shadow bank: written only on an accepted, in-range handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_COEFF); i++) shadow[i] <= '0;
        end else if (shadow_we) begin
            shadow[wr_addr] <= wr_data;
        end
    end

    // Active bank: every coefficient loads on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coeff_flat <= '0;
        end else if (load_active) begin
            for (int i = 0; i < int'(NUM_COEFF); i++)
                coeff_flat[i*COEFF_WIDTH +: COEFF_WIDTH] <= shadow[i];
        end
    end

endmodule
